// File: rtl/uart_transmitter.sv
// 8N1 serial transmitter: one start bit, eight data bits LSB first, one stop bit.
// tx and txe are registered; a new byte is accepted only while txe is high.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 104,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       txe
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       idx, idx_d;
  logic [7:0]       shift, shift_d;
  logic             tx_d, txe_d;
  logic             bit_done;

  assign bit_done = (cnt == CNT_MAX);

  // Next-state logic also computes the next tx/txe so both outputs come from flops.
  always_comb begin
    state_d = state;
    cnt_d   = bit_done ? '0 : cnt + CNT_W'(1);
    idx_d   = idx;
    shift_d = shift;
    tx_d    = tx;
    txe_d   = txe;
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        txe_d = 1'b1;
        if (start) begin
          state_d = START;
          shift_d = data_in;
          tx_d    = 1'b0;
          txe_d   = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = shift[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d = {1'b0, shift[7:1]};
          idx_d   = idx + 3'd1;
          if (idx == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d = shift[1];
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          txe_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        txe_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      tx    <= 1'b1;
      txe   <= 1'b1;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      shift <= shift_d;
      tx    <= tx_d;
      txe   <= txe_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: vector table, hand-written corner sequences and
// randomized traffic checked against a frame-position reference model.
module tb_uart_transmitter;

  localparam int CPB  = 4;
  localparam int CPB2 = 104;

  logic       clk = 1'b0;
  logic       nrst4 = 1'b1, start4 = 1'b0;
  logic [7:0] data4 = '0;
  logic       tx4, txe4;
  logic       nrst104 = 1'b1, start104 = 1'b0;
  logic [7:0] data104 = '0;
  logic       tx104, txe104;

  always #5 clk = ~clk;

  uart_transmitter #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk(clk), .nrst(nrst4), .start(start4), .data_in(data4), .tx(tx4), .txe(txe4)
  );

  uart_transmitter #(.CLKS_PER_BIT(CPB2), .CNT_W(16)) dut104 (
    .clk(clk), .nrst(nrst104), .start(start104), .data_in(data104), .tx(tx104), .txe(txe104)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: position within a 10-bit frame, -1 when idle.
  int         m_pos = -1;
  logic [9:0] m_frame = '1;
  logic [7:0] exp_q[$];

  always @(posedge clk) begin
    if (nrst4) m_pos <= -1;
    else if (m_pos < 0) begin
      if (start4) begin
        m_pos   <= 0;
        m_frame <= {1'b1, data4, 1'b0};
        exp_q.push_back(data4);
      end
    end else if (m_pos == 10 * CPB - 1) m_pos <= -1;
    else m_pos <= m_pos + 1;
  end

  function automatic logic m_tx();
    if (m_pos < 0) return 1'b1;
    return m_frame[m_pos / CPB];
  endfunction

  // Mid-bit sampling receiver on the CPB=4 line.
  logic       prev_tx = 1'b1;
  logic       rx_active = 1'b0;
  int         rx_k = 0;
  logic [9:0] rx_bits = '0;
  logic [7:0] rx_q[$];
  int         rx_sq[$];

  always @(negedge clk) begin
    prev_tx <= tx4;
    if (nrst4) rx_active <= 1'b0;
    else if (!rx_active) begin
      if (prev_tx === 1'b1 && tx4 === 1'b0) begin
        rx_active <= 1'b1;
        rx_k      <= 1;
        rx_sq.push_back(cyc);
      end
    end else begin
      rx_k <= rx_k + 1;
      if (rx_k % CPB == CPB / 2) begin
        rx_bits[rx_k / CPB] <= tx4;
        if (rx_k / CPB == 9) begin
          rx_active <= 1'b0;
          if (tx4 === 1'b1 && rx_bits[0] === 1'b0) rx_q.push_back(rx_bits[8:1]);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    chk($sformatf("tx@%0d", cyc), {31'b0, tx4}, {31'b0, m_tx()});
    chk($sformatf("txe@%0d", cyc), {31'b0, txe4}, {31'b0, (m_pos < 0)});
  endtask

  typedef struct {
    logic       nrst;
    logic       start;
    logic [7:0] data;
    logic       exp_tx;
    logic       exp_txe;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [7:0] b2b[2];
    logic [9:0] fr;
    int good[10];
    int busy;
    int sel;

    // reset with start held, then accept 0x48 and watch its first cycles
    vecs[0] = '{1'b1, 1'b1, 8'h48, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 8'h48, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 8'h48, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 8'h48, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

    for (int i = 0; i < 8; i++) begin
      nrst4  = vecs[i].nrst;
      start4 = vecs[i].start;
      data4  = vecs[i].data;
      step();
      chk($sformatf("vec%0d tx", i), {31'b0, tx4}, {31'b0, vecs[i].exp_tx});
      chk($sformatf("vec%0d txe", i), {31'b0, txe4}, {31'b0, vecs[i].exp_txe});
    end
    repeat (36) step();
    chk("h txe after frame", {31'b0, txe4}, 32'd1);
    chk("h rx count", rx_q.size(), 1);
    if (rx_q.size() >= 1) chk("h rx byte", {24'b0, rx_q[0]}, 32'h48);

    // back-to-back with start tied to txe
    rx_q.delete();
    rx_sq.delete();
    b2b[0] = 8'h55;
    b2b[1] = 8'h0A;
    sel = 0;
    for (int i = 0; i < 100; i++) begin
      if (txe4 && sel < 2) begin
        start4 = 1'b1;
        data4  = b2b[sel];
        sel++;
      end else begin
        start4 = txe4 && sel < 2;
        data4  = 8'($urandom);
      end
      step();
    end
    start4 = 1'b0;
    chk("b2b rx count", rx_q.size(), 2);
    if (rx_q.size() >= 2) begin
      chk("b2b byte0", {24'b0, rx_q[0]}, 32'h55);
      chk("b2b byte1", {24'b0, rx_q[1]}, 32'h0A);
      chk("b2b period", rx_sq[1] - rx_sq[0], 10 * CPB + 1);
    end

    // busy rejection
    rx_q.delete();
    start4 = 1'b1;
    data4  = 8'hFF;
    step();
    for (int i = 1; i < 60; i++) begin
      start4 = (i >= 15 && i < 20);
      data4  = start4 ? 8'h00 : 8'hFF;
      step();
    end
    chk("busy rx count", rx_q.size(), 1);
    if (rx_q.size() >= 1) chk("busy byte", {24'b0, rx_q[0]}, 32'hFF);
    chk("busy idle txe", {31'b0, txe4}, 32'd1);

    // reset mid-frame, then a fresh frame
    rx_q.delete();
    start4 = 1'b1;
    data4  = 8'h00;
    step();
    start4 = 1'b0;
    repeat (19) step();
    nrst4 = 1'b1;
    step();
    chk("midrst tx", {31'b0, tx4}, 32'd1);
    chk("midrst txe", {31'b0, txe4}, 32'd1);
    nrst4 = 1'b0;
    repeat (3) step();
    start4 = 1'b1;
    data4  = 8'hA5;
    step();
    start4 = 1'b0;
    repeat (45) step();
    chk("midrst rx count", rx_q.size(), 1);
    if (rx_q.size() >= 1) chk("midrst byte", {24'b0, rx_q[0]}, 32'hA5);

    // randomized traffic
    rx_q.delete();
    exp_q.delete();
    for (int i = 0; i < 800; i++) begin
      start4 = ($urandom_range(3) == 0);
      data4  = 8'($urandom);
      step();
    end
    start4 = 1'b0;
    repeat (45) step();
    chk("rand frame count", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk($sformatf("rand byte%0d", i), {24'b0, rx_q[i]}, {24'b0, exp_q[i]});

    // CLKS_PER_BIT=104, byte 0x21
    nrst104  = 1'b0;
    start104 = 1'b1;
    data104  = 8'h21;
    step();
    start104 = 1'b0;
    fr = {1'b1, 8'h21, 1'b0};
    busy = 0;
    for (int b = 0; b < 10; b++) good[b] = 0;
    for (int k = 0; k < 10 * CPB2; k++) begin
      if (tx104 === fr[k / CPB2]) good[k / CPB2]++;
      if (txe104 === 1'b0) busy++;
      step();
    end
    for (int b = 0; b < 10; b++) chk($sformatf("slow bit%0d cycles", b), good[b], CPB2);
    chk("slow frame len", busy, 10 * CPB2);
    chk("slow txe end", {31'b0, txe104}, 32'd1);
    chk("slow tx end", {31'b0, tx104}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- 8N1 asynchronous serial transmitter: accepts one byte per handshake, serialises it LSB-first on `tx` with one start bit and one stop bit.
- Feeds an off-chip UART receiver from a byte source, e.g. a ROM sequencer that ties `start` to `txe` and advances its address whenever `txe` is high.
- `txe` ("transmitter empty") is the ready flag; `start` is the request.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per serial bit (12 MHz / 115200 baud). Legal range 2..65535.
- CNT_W, 16, width of the internal bit-period counter. Must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- nrst  input  1  synchronous, active-high reset. The name is kept for codebase compatibility; it is sampled on the rising clk edge.
- start  input  1  request to send `data_in`; acted on only when `txe`=1.
- data_in  input  8  byte to send; sampled on the accepting edge only.
- tx  output  1  serial line, idle high; registered output.
- txe  output  1  1 = idle and ready to accept a byte; registered output.

Behaviour:
- Reset: while nrst=1 at a clk edge, the block forces:
  - state=IDLE, tx=1, txe=1;
  - bit counter=0, bit index=0, shift register=0.
  - Reset has priority over everything, including mid-frame; an aborted frame is dropped with no stop bit, and tx returns to 1 on the next edge.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1, txe=1.
  - On an edge with start=1, the block latches data_in into the shift register, enters START, loads the counter to 0 and clears txe.
  - tx=0 from the following cycle.
  - start=0 keeps the block in IDLE.
- START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA:
  - tx=shift[0] for CLKS_PER_BIT cycles, then shift right by one and increment the bit index.
  - After bit 7 (bit index wraps from 7), go to STOP.
  - Bit order is LSB first: d0..d7.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles, then IDLE with txe=1.
  - The last stop cycle is followed by txe=1 on the next edge.
- Latency: tx falls 1 cycle after the accepting edge.
- Frame length: 10*CLKS_PER_BIT cycles from the first start-bit cycle to the end of the stop bit.
- Back-to-back (start held at 1, or start tied to txe):
  - txe is high for exactly one cycle between frames.
  - Frame-to-frame period = 10*CLKS_PER_BIT + 1 cycles.
  - The extra idle cycle carries tx=1, lengthening the stop bit by one cycle.
- Busy behaviour:
  - start while txe=0 is ignored, with no queuing.
  - data_in changes during a frame have no effect.
- Counter: compares against CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. No drift is accumulated across bits.
- Outputs are glitch-free: tx and txe come from flops, not decoded combinationally.

Test Plan (bench uses CLKS_PER_BIT=4 unless stated):
1. Reset: hold nrst=1 for 3 cycles with start=1 -> tx=1, txe=1 throughout; no frame begins while nrst=1.
2. Single byte 0x48 ('H'): pulse start for 1 cycle in IDLE -> txe=0 next cycle, and tx over 40 cycles is:
   - 0 (start bit);
   - bits 0,0,0,1,0,0,1,0 (LSB first);
   - 1 (stop bit), each held 4 cycles;
   - then txe=1.
3. Back-to-back with start tied to txe, sending 0x55 then 0x0A -> frames start exactly 41 cycles apart, txe=1 for exactly one cycle between them, and both bytes decode correctly.
4. Busy rejection: start a frame with 0xFF; at cycle 15 assert start with data_in=0x00 for 5 cycles -> frame still decodes 0xFF; no second frame after the stop bit if start is low by then.
5. Reset mid-frame: assert nrst at cycle 20 of a 0x00 frame -> tx=1 and txe=1 on the next edge; a fresh start afterwards sends a complete, correct frame.
6. CLKS_PER_BIT=104: send 0x21 -> each bit lasts exactly 104 cycles and the frame lasts 1040 cycles.
